// File: rtl/change_dispense_ctrl.sv
// Vending credit/vend/change sequencer: collects coins, vends at PRICE or refunds on cancel,
// shows the pending change for DISP_CYCLES cycles, then pays it out one unit per hopper ack.
module change_dispense_ctrl #(
  parameter int PRICE       = 3,
  parameter int DISP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  output logic [3:0] credit,
  output logic       vend,
  output logic [3:0] chg_code,
  output logic       chg_req,
  input  logic       chg_ack,
  output logic       coin_reject,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_VEND    = 3'd2;
  localparam logic [2:0] S_SHOW    = 3'd3;
  localparam logic [2:0] S_PAY     = 3'd4;

  localparam int         CW        = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(DISP_CYCLES - 1);
  localparam logic [3:0] PRICE_V   = 4'(PRICE);

  logic [2:0]    state;
  logic [3:0]    chg_reg;
  logic [CW-1:0] show_cnt;

  logic       coin_ok;
  logic       accepting;
  logic       take_cancel;
  logic [3:0] coin_val;
  logic [4:0] sum_wide;
  logic [3:0] sum;

  // Handshake: chg_req stays high for the whole PAY state; every clock edge that
  // sees chg_ack high while chg_req is high consumes exactly one unit of change.
  always_comb begin
    coin_ok  = coin_valid && (coin_type != 2'b00);
    coin_val = 4'd0;
    if (coin_ok) begin
      case (coin_type)
        2'b01:   coin_val = 4'd1;
        2'b10:   coin_val = 4'd2;
        default: coin_val = 4'd10;
      endcase
    end
    sum_wide    = {1'b0, credit} + {1'b0, coin_val};
    sum         = (sum_wide > 5'd15) ? 4'd15 : sum_wide[3:0];
    accepting   = (state == S_IDLE) || (state == S_COLLECT);
    // sum doubles as the refund; zero only in IDLE with no usable coin
    take_cancel = accepting && cancel && (sum != 4'd0);
  end

  assign vend     = (state == S_VEND);
  assign busy     = (state == S_VEND) || (state == S_SHOW) || (state == S_PAY);
  assign chg_req  = (state == S_PAY);
  assign chg_code = ((state == S_SHOW) || (state == S_PAY)) ? chg_reg : 4'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      credit      <= 4'd0;
      chg_reg     <= 4'd0;
      show_cnt    <= '0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= coin_ok && busy;
      case (state)
        S_IDLE, S_COLLECT: begin
          if (take_cancel) begin
            credit   <= 4'd0;
            chg_reg  <= sum;
            show_cnt <= '0;
            state    <= S_SHOW;
          end else if (coin_ok) begin
            if (sum < PRICE_V) begin
              credit <= sum;
              state  <= S_COLLECT;
            end else begin
              credit  <= 4'd0;
              chg_reg <= sum - PRICE_V;
              state   <= S_VEND;
            end
          end
        end
        S_VEND: begin
          show_cnt <= '0;
          state    <= (chg_reg != 4'd0) ? S_SHOW : S_IDLE;
        end
        S_SHOW: begin
          if (show_cnt == SHOW_LAST) state <= S_PAY;
          else show_cnt <= show_cnt + 1'b1;
        end
        S_PAY: begin
          if (chg_ack) begin
            chg_reg <= chg_reg - 4'd1;
            if (chg_reg == 4'd1) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl (PRICE=3, DISP_CYCLES=4) with hand-computed expectations.
module tb_change_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic [3:0] credit;
  logic       vend;
  logic [3:0] chg_code;
  logic       chg_req;
  logic       chg_ack;
  logic       coin_reject;
  logic       busy;

  int errors = 0;
  int checks = 0;

  change_dispense_ctrl #(.PRICE(3), .DISP_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .credit(credit), .vend(vend), .chg_code(chg_code),
    .chg_req(chg_req), .chg_ack(chg_ack), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  // packed view: {credit, vend, chg_code, chg_req, coin_reject, busy}
  function automatic logic [11:0] obs();
    return {credit, vend, chg_code, chg_req, coin_reject, busy};
  endfunction

  function automatic logic [11:0] ex(input logic [3:0] cr, input logic v, input logic [3:0] cc,
                                      input logic rq, input logic rj, input logic b);
    return {cr, v, cc, rq, rj, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [1:0] ct, input logic cn, input logic ak);
    coin_valid = cv;
    coin_type  = ct;
    cancel     = cn;
    chg_ack    = ak;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 2'b00, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 12'd0) begin
      errors++; $display("FAIL reset_held: got %h want %h", obs(), 12'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (obs() !== 12'd0) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs(), 12'd0);
    end
  endtask

  task automatic test_exact_price();
    logic [11:0] e;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 2'b01, 0, 0);
      step();
      e = (i < 3) ? ex(4'(i), 0, 0, 0, 0, 0) : ex(0, 1, 0, 0, 0, 1);
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL exact_coin%0d: got %h want %h", i, obs(), e);
      end
    end
    drive(0, 2'b00, 0, 0);
    step();
    checks++;
    if (obs() !== 12'd0) begin
      errors++; $display("FAIL exact_idle: got %h want %h", obs(), 12'd0);
    end
  endtask

  task automatic test_big_change();
    logic [11:0] e;
    drive(1, 2'b11, 0, 0);
    step();
    checks++;
    if (obs() !== ex(0, 1, 0, 0, 0, 1)) begin
      errors++; $display("FAIL big_vend: got %h want %h", obs(), ex(0, 1, 0, 0, 0, 1));
    end
    drive(0, 2'b00, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (obs() !== ex(0, 0, 7, 0, 0, 1)) begin
        errors++; $display("FAIL big_show%0d: got %h want %h", i, obs(), ex(0, 0, 7, 0, 0, 1));
      end
    end
    step();
    checks++;
    if (obs() !== ex(0, 0, 7, 1, 0, 1)) begin
      errors++; $display("FAIL big_pay_start: got %h want %h", obs(), ex(0, 0, 7, 1, 0, 1));
    end
    for (int i = 1; i <= 7; i++) begin
      chg_ack = 1'b1;
      step();
      e = ex(0, 0, 4'(7 - i), (i < 7), 0, (i < 7));
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL big_ack%0d: got %h want %h", i, obs(), e);
      end
      chg_ack = 1'b0;
      if (i < 7) begin
        step();
        checks++;
        if (obs() !== e) begin
          errors++; $display("FAIL big_gap%0d: got %h want %h", i, obs(), e);
        end
      end
    end
  endtask

  task automatic test_cancel_refund();
    logic [11:0] e;
    drive(1, 2'b01, 0, 0);
    step();
    checks++;
    if (obs() !== ex(1, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL cancel_pre: got %h want %h", obs(), ex(1, 0, 0, 0, 0, 0));
    end
    drive(1, 2'b10, 1, 0);
    step();
    drive(0, 2'b00, 0, 0);
    checks++;
    if (obs() !== ex(0, 0, 3, 0, 0, 1)) begin
      errors++; $display("FAIL cancel_show: got %h want %h", obs(), ex(0, 0, 3, 0, 0, 1));
    end
    repeat (3) step();
    step();
    checks++;
    if (obs() !== ex(0, 0, 3, 1, 0, 1)) begin
      errors++; $display("FAIL cancel_pay: got %h want %h", obs(), ex(0, 0, 3, 1, 0, 1));
    end
    chg_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      e = ex(0, 0, 4'(3 - i), (i < 3), 0, (i < 3));
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL cancel_ack%0d: got %h want %h", i, obs(), e);
      end
    end
    chg_ack = 1'b0;
  endtask

  task automatic test_busy_reject();
    drive(1, 2'b11, 0, 0);
    step();
    drive(0, 2'b00, 0, 0);
    step();
    drive(1, 2'b11, 0, 0);
    step();
    drive(0, 2'b00, 0, 0);
    checks++;
    if (obs() !== ex(0, 0, 7, 0, 1, 1)) begin
      errors++; $display("FAIL reject_pulse: got %h want %h", obs(), ex(0, 0, 7, 0, 1, 1));
    end
    step();
    checks++;
    if (obs() !== ex(0, 0, 7, 0, 0, 1)) begin
      errors++; $display("FAIL reject_clear: got %h want %h", obs(), ex(0, 0, 7, 0, 0, 1));
    end
    step();
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (obs() !== ex(0, 0, 7, 1, 0, 1)) begin
      errors++; $display("FAIL cancel_in_pay: got %h want %h", obs(), ex(0, 0, 7, 1, 0, 1));
    end
    drive(1, 2'b00, 0, 0);
    step();
    drive(0, 2'b00, 0, 0);
    step();
    checks++;
    if (obs() !== ex(0, 0, 7, 1, 0, 1)) begin
      errors++; $display("FAIL null_coin_busy: got %h want %h", obs(), ex(0, 0, 7, 1, 0, 1));
    end
    chg_ack = 1'b1;
    repeat (7) step();
    chg_ack = 1'b0;
    checks++;
    if (obs() !== 12'd0) begin
      errors++; $display("FAIL reject_drain: got %h want %h", obs(), 12'd0);
    end
  endtask

  task automatic test_single_change();
    drive(1, 2'b10, 0, 0);
    step();
    checks++;
    if (obs() !== ex(2, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL single_c1: got %h want %h", obs(), ex(2, 0, 0, 0, 0, 0));
    end
    step();
    drive(0, 2'b00, 0, 0);
    checks++;
    if (obs() !== ex(0, 1, 0, 0, 0, 1)) begin
      errors++; $display("FAIL single_vend: got %h want %h", obs(), ex(0, 1, 0, 0, 0, 1));
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (obs() !== ex(0, 0, 1, 0, 0, 1)) begin
        errors++; $display("FAIL single_show%0d: got %h want %h", i, obs(), ex(0, 0, 1, 0, 0, 1));
      end
    end
    step();
    checks++;
    if (obs() !== ex(0, 0, 1, 1, 0, 1)) begin
      errors++; $display("FAIL single_pay: got %h want %h", obs(), ex(0, 0, 1, 1, 0, 1));
    end
    chg_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (obs() !== 12'd0) begin
        errors++; $display("FAIL single_ack_idle%0d: got %h want %h", i, obs(), 12'd0);
      end
    end
    drive(0, 2'b00, 1, 0);
    step();
    cancel = 1'b0;
    checks++;
    if (obs() !== 12'd0) begin
      errors++; $display("FAIL idle_cancel: got %h want %h", obs(), 12'd0);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 2'b01, 0, 0);
    step();
    coin_type = 2'b10;
    step();
    coin_type = 2'b01;
    checks++;
    if (obs() !== ex(0, 1, 0, 0, 0, 1)) begin
      errors++; $display("FAIL b2b_vend: got %h want %h", obs(), ex(0, 1, 0, 0, 0, 1));
    end
    step();
    checks++;
    if (obs() !== ex(0, 0, 0, 0, 1, 0)) begin
      errors++; $display("FAIL b2b_reject_in_vend: got %h want %h", obs(), ex(0, 0, 0, 0, 1, 0));
    end
    step();
    drive(0, 2'b00, 1, 0);
    checks++;
    if (obs() !== ex(1, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL b2b_recollect: got %h want %h", obs(), ex(1, 0, 0, 0, 0, 0));
    end
    step();
    cancel = 1'b0;
    checks++;
    if (obs() !== ex(0, 0, 1, 0, 0, 1)) begin
      errors++; $display("FAIL b2b_refund: got %h want %h", obs(), ex(0, 0, 1, 0, 0, 1));
    end
    repeat (4) step();
    chg_ack = 1'b1;
    step();
    chg_ack = 1'b0;
    checks++;
    if (obs() !== 12'd0) begin
      errors++; $display("FAIL b2b_done: got %h want %h", obs(), 12'd0);
    end
  endtask

  task automatic test_reset_in_pay();
    drive(1, 2'b11, 0, 0);
    step();
    drive(0, 2'b00, 0, 0);
    repeat (5) step();
    chg_ack = 1'b1;
    repeat (2) step();
    chg_ack = 1'b0;
    checks++;
    if (obs() !== ex(0, 0, 5, 1, 0, 1)) begin
      errors++; $display("FAIL rst_pay_pre: got %h want %h", obs(), ex(0, 0, 5, 1, 0, 1));
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 12'd0) begin
      errors++; $display("FAIL rst_pay_async: got %h want %h", obs(), 12'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (obs() !== 12'd0) begin
      errors++; $display("FAIL rst_pay_after: got %h want %h", obs(), 12'd0);
    end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_big_change();
    test_cancel_refund();
    test_busy_reject();
    test_single_change();
    test_back_to_back();
    test_reset_in_pay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
